// File: rtl/dsp_pipe_pkg.sv
// Shared definitions for the bundle pipeline control slice: operand/tag sizing,
// scheduler state encodings, the NOP bundle and the tag-match helper.
package dsp_pipe_pkg;

   localparam int TAG_W  = 5;   // 32 architectural registers
   localparam int NSRC   = 8;   // two source operands for each of the four slots
   localparam int SLOT_N = 4;   // A0 / A1 / M / LS

   // Scheduler states; the encoding is visible on the ctrl_state debug port.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_LDSTALL = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_FLUSH   = 2'd3
   } ctrl_state_e;

   // All-zero bundle: every slot decodes to NOP.
   localparam logic [SLOT_N*32-1:0] NOP_BUNDLE = {SLOT_N{32'h0000_0000}};

   // A source tag depends on a load only when the tags match and the load
   // really writes a register (r0 is hard-wired to zero, so it never hazards).
   function automatic logic tag_hit(input logic [TAG_W-1:0] src_tag,
                                    input logic [TAG_W-1:0] ld_tag);
      return (src_tag == ld_tag) && (ld_tag != {TAG_W{1'b0}});
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: compares every ID source tag against the destination tag of the
// load sitting in EX and reports a load-use hazard.
module hazard_cmp
   import dsp_pipe_pkg::*;
#(
   parameter int TAG_W_P = TAG_W,
   parameter int NSRC_P  = NSRC
) (
   input  logic                      id_valid,
   input  logic [NSRC_P*TAG_W_P-1:0] src_tags,
   input  logic                      ld_valid,
   input  logic [TAG_W_P-1:0]        ld_tag,
   output logic                      hazard
);

   logic any_hit_s;

   // OR-reduce the per-operand tag matches (r0 masked inside tag_hit).
   always_comb begin
      any_hit_s = 1'b0;
      for (int i = 0; i < NSRC_P; i++) begin
         if (tag_hit(src_tags[i*TAG_W_P +: TAG_W_P], ld_tag)) begin
            any_hit_s = 1'b1;
         end else begin
            any_hit_s = any_hit_s;
         end
      end
   end

   assign hazard = id_valid & ld_valid & any_hit_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline scheduler for the 4-slot bundle datapath.
// Stalls on load-use hazards, freezes the back end while data memory is busy
// and holds flush_ifid for FLUSH_CYCLES cycles after a jump mispredict.
// Outputs are decoded from the current state and inputs in the same cycle.
// Optional build macro: PIPE_CTRL_PERF_EN enables the stall/flush perf counters;
// without it stall_cnt and flush_cnt read as zero.
module pipe_hazard_ctrl
   import dsp_pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,   // 1..15
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    id_valid,
   input  logic [NSRC*TAG_W-1:0]   id_src_tags,
   input  logic                    ex_ld_valid,
   input  logic [TAG_W-1:0]        ex_ld_tag,
   input  logic                    mem_busy,
   input  logic                    mispredict,
   output logic                    stall_pc,
   output logic                    stall_ifid,
   output logic                    bubble_idex,
   output logic                    freeze_back,
   output logic                    flush_ifid,
   output logic [1:0]              ctrl_state,
   output logic [CNT_W-1:0]        stall_cnt,
   output logic [CNT_W-1:0]        flush_cnt
);

   localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

   ctrl_state_e state_r, state_nxt;
   logic [3:0]  flush_left_r, left_nxt;
   logic        flush_pend_r, pend_nxt;
   logic        hazard_s;
   logic        go_flush_s;
   logic        enter_flush_s;
   logic        stall_pc_s, stall_ifid_s, bubble_idex_s, freeze_back_s, flush_ifid_s;

   hazard_cmp #(
      .TAG_W_P (TAG_W),
      .NSRC_P  (NSRC)
   ) u_hazard_cmp (
      .id_valid (id_valid),
      .src_tags (id_src_tags),
      .ld_valid (ex_ld_valid),
      .ld_tag   (ex_ld_tag),
      .hazard   (hazard_s)
   );

   // A mispredict parked during a memory wait is serviced as soon as the wait ends.
   assign go_flush_s = mispredict | flush_pend_r;

   // Next-state and control decode; priority is mem_busy, then flush, then hazard.
   always_comb begin
      state_nxt     = state_r;
      left_nxt      = flush_left_r;
      pend_nxt      = flush_pend_r;
      enter_flush_s = 1'b0;
      stall_pc_s    = 1'b0;
      stall_ifid_s  = 1'b0;
      bubble_idex_s = 1'b0;
      freeze_back_s = 1'b0;
      flush_ifid_s  = 1'b0;

      if (mem_busy) begin
         // Whole pipe frozen; the flush countdown holds its value.
         stall_pc_s    = 1'b1;
         stall_ifid_s  = 1'b1;
         freeze_back_s = 1'b1;
         state_nxt     = ST_MEMWAIT;
         if (mispredict) begin
            pend_nxt = 1'b1;
         end else begin
            pend_nxt = flush_pend_r;
         end
      end else begin
         case (state_r)
            ST_RUN, ST_MEMWAIT: begin
               if (go_flush_s) begin
                  enter_flush_s = 1'b1;
               end else if (hazard_s) begin
                  stall_pc_s    = 1'b1;
                  stall_ifid_s  = 1'b1;
                  bubble_idex_s = 1'b1;
                  state_nxt     = ST_LDSTALL;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
            ST_LDSTALL: begin
               // The load has moved to MEM, so the hazard is resolved this cycle.
               if (go_flush_s) begin
                  enter_flush_s = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
            ST_FLUSH: begin
               flush_ifid_s = 1'b1;
               if (go_flush_s) begin
                  enter_flush_s = 1'b1;
               end else if (flush_left_r <= 4'd1) begin
                  left_nxt  = 4'd0;
                  state_nxt = ST_RUN;
               end else begin
                  left_nxt  = flush_left_r - 4'd1;
                  state_nxt = ST_FLUSH;
               end
            end
            default: begin
               state_nxt = ST_RUN;
            end
         endcase
      end

      if (enter_flush_s) begin
         flush_ifid_s = 1'b1;
         left_nxt     = FLUSH_RELOAD;
         pend_nxt     = 1'b0;
         state_nxt    = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
      end else begin
         flush_ifid_s = flush_ifid_s;
      end
   end

   // Scheduler state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_RUN;
         flush_left_r <= 4'd0;
         flush_pend_r <= 1'b0;
      end else begin
         state_r      <= state_nxt;
         flush_left_r <= left_nxt;
         flush_pend_r <= pend_nxt;
      end
   end

   // Every output is forced low for as long as reset is held.
   assign stall_pc    = rst_n & stall_pc_s;
   assign stall_ifid  = rst_n & stall_ifid_s;
   assign bubble_idex = rst_n & bubble_idex_s;
   assign freeze_back = rst_n & freeze_back_s;
   assign flush_ifid  = rst_n & flush_ifid_s;
   assign ctrl_state  = rst_n ? state_r : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   // Saturating perf counters: stalled-PC cycles and serviced mispredicts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         flush_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_pc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (enter_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
            flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign stall_cnt = rst_n ? stall_cnt_r : {CNT_W{1'b0}};
   assign flush_cnt = rst_n ? flush_cnt_r : {CNT_W{1'b0}};
`else
   assign stall_cnt = {CNT_W{1'b0}};
   assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2).
// A second instance with CNT_W=2 exercises perf-counter saturation.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [39:0] id_src_tags;
   logic        ex_ld_valid;
   logic [4:0]  ex_ld_tag;
   logic        mem_busy;
   logic        mispredict;

   logic        stall_pc, stall_ifid, bubble_idex, freeze_back, flush_ifid;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cnt, flush_cnt;

   logic        s_stall_pc, s_stall_ifid, s_bubble_idex, s_freeze_back, s_flush_ifid;
   logic [1:0]  s_ctrl_state;
   logic [1:0]  s_stall_cnt, s_flush_cnt;

   logic [4:0]  outs;
   int          total = 0;
   int          bad   = 0;

   assign outs = {stall_pc, stall_ifid, bubble_idex, freeze_back, flush_ifid};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_tags(id_src_tags),
      .ex_ld_valid(ex_ld_valid), .ex_ld_tag(ex_ld_tag), .mem_busy(mem_busy),
      .mispredict(mispredict), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
      .bubble_idex(bubble_idex), .freeze_back(freeze_back), .flush_ifid(flush_ifid),
      .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_tags(id_src_tags),
      .ex_ld_valid(ex_ld_valid), .ex_ld_tag(ex_ld_tag), .mem_busy(mem_busy),
      .mispredict(mispredict), .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid),
      .bubble_idex(s_bubble_idex), .freeze_back(s_freeze_back), .flush_ifid(s_flush_ifid),
      .ctrl_state(s_ctrl_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   task automatic idle_inputs();
      id_valid    = 1'b0;
      id_src_tags = 40'd0;
      ex_ld_valid = 1'b0;
      ex_ld_tag   = 5'd0;
      mem_busy    = 1'b0;
      mispredict  = 1'b0;
   endtask

   // Load in EX writes r7; a1_R1 (operand 3) reads r7, other operands read r10..r17.
   task automatic hazard_inputs();
      id_valid    = 1'b1;
      ex_ld_valid = 1'b1;
      ex_ld_tag   = 5'd7;
      for (int j = 0; j < 8; j++) begin
         id_src_tags[j*5 +: 5] = (j == 3) ? 5'd7 : 5'(j + 10);
      end
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      hazard_inputs();
      mem_busy   = 1'b1;
      mispredict = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (outs !== 5'b00000 || ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_outs cyc%0d: outs=%b state=%0d want outs=00000 state=0", c, outs, ctrl_state);
         end
         total++;
         if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_cnt cyc%0d: stall_cnt=%0d flush_cnt=%0d want 0 0", c, stall_cnt, flush_cnt);
         end
         step();
      end
      rst_n = 1'b1;
      idle_inputs();
      settle();
      total++;
      if (outs !== 5'b00000 || ctrl_state !== 2'd0) begin
         bad++;
         $display("FAIL reset_release: outs=%b state=%0d want outs=00000 state=0", outs, ctrl_state);
      end
      step();
   endtask

   // The r7 match is moved through every operand position in turn.
   task automatic test_load_use();
      for (int i = 0; i < 8; i++) begin
         id_valid    = 1'b1;
         ex_ld_valid = 1'b1;
         ex_ld_tag   = 5'd7;
         for (int j = 0; j < 8; j++) begin
            id_src_tags[j*5 +: 5] = (j == i) ? 5'd7 : 5'(j + 10);
         end
         settle();
         total++;
         if (outs !== 5'b11100 || ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL load_use_hit op%0d: outs=%b state=%0d want outs=11100 state=0", i, outs, ctrl_state);
         end
         step();
         idle_inputs();
         settle();
         total++;
         if (outs !== 5'b00000 || ctrl_state !== 2'd1) begin
            bad++;
            $display("FAIL load_use_ldstall op%0d: outs=%b state=%0d want outs=00000 state=1", i, outs, ctrl_state);
         end
         step();
         settle();
         total++;
         if (outs !== 5'b00000 || ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL load_use_back op%0d: outs=%b state=%0d want outs=00000 state=0", i, outs, ctrl_state);
         end
         step();
      end
   endtask

   task automatic test_no_hazard();
      for (int k = 0; k < 4; k++) begin
         hazard_inputs();
         case (k)
            0: begin
               ex_ld_tag   = 5'd0;
               id_src_tags = 40'd0;
            end
            1: id_valid    = 1'b0;
            2: ex_ld_valid = 1'b0;
            default: begin
               ex_ld_tag = 5'd6;
               for (int j = 0; j < 8; j++) id_src_tags[j*5 +: 5] = 5'd7;
            end
         endcase
         settle();
         total++;
         if (outs !== 5'b00000 || ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL no_hazard case%0d: outs=%b state=%0d want outs=00000 state=0", k, outs, ctrl_state);
         end
         step();
         settle();
         total++;
         if (ctrl_state !== 2'd0) begin
            bad++;
            $display("FAIL no_hazard_next case%0d: state=%0d want 0", k, ctrl_state);
         end
         idle_inputs();
         step();
      end
   endtask

   task automatic test_flush();
      logic [4:0] exp_o [3] = '{5'b00001, 5'b00001, 5'b00000};
      logic [1:0] exp_s [3] = '{2'd0, 2'd3, 2'd0};
      for (int c = 0; c < 3; c++) begin
         idle_inputs();
         mispredict = (c == 0);
         settle();
         total++;
         if (outs !== exp_o[c] || ctrl_state !== exp_s[c]) begin
            bad++;
            $display("FAIL flush cyc%0d: outs=%b state=%0d want outs=%b state=%0d", c, outs, ctrl_state, exp_o[c], exp_s[c]);
         end
         step();
      end
   endtask

   task automatic test_mem_wait();
      logic       busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      logic       mp    [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic [4:0] exp_o [6] = '{5'b11010, 5'b11010, 5'b11010, 5'b00001, 5'b00001, 5'b00000};
      logic [1:0] exp_s [6] = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
      for (int c = 0; c < 6; c++) begin
         idle_inputs();
         mem_busy   = busy[c];
         mispredict = mp[c];
         settle();
         total++;
         if (outs !== exp_o[c] || ctrl_state !== exp_s[c]) begin
            bad++;
            $display("FAIL mem_wait cyc%0d: outs=%b state=%0d want outs=%b state=%0d", c, outs, ctrl_state, exp_o[c], exp_s[c]);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic       rst   [14] = '{1,1,1,1,1,1,0,1,1,0,1,1,1,1};
      logic       hz    [14] = '{1,1,1,0,0,0,0,0,0,0,0,0,0,0};
      logic       mp    [14] = '{1,0,0,0,1,1,0,0,1,0,0,1,0,0};
      logic       busy  [14] = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0};
      logic [4:0] exp_o [14] = '{5'b00001, 5'b00001, 5'b11100, 5'b00000, 5'b00001, 5'b00001, 5'b00000,
                                 5'b00000, 5'b11010, 5'b00000, 5'b00000, 5'b00001, 5'b00001, 5'b00000};
      logic [1:0] exp_s [14] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0,
                                 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
      for (int c = 0; c < 14; c++) begin
         idle_inputs();
         if (hz[c]) hazard_inputs();
         rst_n      = rst[c];
         mispredict = mp[c];
         mem_busy   = busy[c];
         settle();
         total++;
         if (outs !== exp_o[c] || ctrl_state !== exp_s[c]) begin
            bad++;
            $display("FAIL back_to_back cyc%0d: outs=%b state=%0d want outs=%b state=%0d", c, outs, ctrl_state, exp_o[c], exp_s[c]);
         end
         step();
      end
      rst_n = 1'b1;
   endtask

   task automatic test_perf();
      // 0=idle 1=hazard 2=mispredict 3=mem_busy
      int         kind [17] = '{1,0,1,0,3,3,0,2,0,2,0,0,2,0,2,0,0};
      logic [15:0] exp_st, exp_fl1, exp_fl2;
      logic [1:0]  exp_sst, exp_sfl1, exp_sfl2;
`ifdef PIPE_CTRL_PERF_EN
      exp_st   = 16'd4;
      exp_fl1  = 16'd2;
      exp_fl2  = 16'd4;
      exp_sst  = 2'd3;
      exp_sfl1 = 2'd2;
      exp_sfl2 = 2'd3;
`else
      exp_st   = 16'd0;
      exp_fl1  = 16'd0;
      exp_fl2  = 16'd0;
      exp_sst  = 2'd0;
      exp_sfl1 = 2'd0;
      exp_sfl2 = 2'd0;
`endif
      idle_inputs();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 17; c++) begin
         idle_inputs();
         case (kind[c])
            1: hazard_inputs();
            2: mispredict = 1'b1;
            3: mem_busy   = 1'b1;
            default: mispredict = 1'b0;
         endcase
         settle();
         if (c == 11) begin
            total++;
            if (stall_cnt !== exp_st || flush_cnt !== exp_fl1) begin
               bad++;
               $display("FAIL perf_counts: stall_cnt=%0d flush_cnt=%0d want %0d %0d", stall_cnt, flush_cnt, exp_st, exp_fl1);
            end
            total++;
            if (s_stall_cnt !== exp_sst || s_flush_cnt !== exp_sfl1) begin
               bad++;
               $display("FAIL perf_sat_stall: stall_cnt=%0d flush_cnt=%0d want %0d %0d", s_stall_cnt, s_flush_cnt, exp_sst, exp_sfl1);
            end
         end
         step();
      end
      settle();
      total++;
      if (flush_cnt !== exp_fl2 || s_flush_cnt !== exp_sfl2) begin
         bad++;
         $display("FAIL perf_sat_flush: flush_cnt=%0d small=%0d want %0d %0d", flush_cnt, s_flush_cnt, exp_fl2, exp_sfl2);
      end
      total++;
      if (stall_cnt !== exp_st || s_stall_cnt !== exp_sst) begin
         bad++;
         $display("FAIL perf_stall_hold: stall_cnt=%0d small=%0d want %0d %0d", stall_cnt, s_stall_cnt, exp_st, exp_sst);
      end
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      step();
      test_reset();
      test_load_use();
      test_no_hazard();
      test_flush();
      test_mem_wait();
      test_back_to_back();
      test_perf();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
